sigma_delta_adc_sequencer: RTL and testbench
============================================

SIGMA_DELTA_ADC_SEQUENCER -- requirements
Module: sigma_delta_adc_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of analog-mux inputs sharing one sigma-delta ADC.
REQ-002 SHALL have parameter ADC_BITLEN, default 16: width of the decimated sample.
REQ-003 SHALL have parameter DISCARD_SAMPLES, default 2: number of decimator outputs dropped after each mux change (CIC settling).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: begin a scan.
REQ-007 SHALL have port stop, input, 1 bit: abort a scan.
REQ-008 SHALL have port continuous, input, 1 bit: repeat the scan indefinitely when high.
REQ-009 SHALL have port chan_mask, input, NUM_CHANNELS bits: enabled channels.
REQ-010 SHALL have port adc_s_sample, input, ADC_BITLEN bits, signed: ADC output.
REQ-011 SHALL have port adc_valid, input, 1 bit: one-cycle sample strobe from the ADC.
REQ-012 SHALL have port mux_sel, output, $clog2(NUM_CHANNELS) bits: analog mux select.
REQ-013 SHALL have port res_data, output, ADC_BITLEN bits: captured result.
REQ-014 SHALL have port res_channel, output, $clog2(NUM_CHANNELS) bits: channel of res_data.
REQ-015 SHALL have port res_valid, output, 1 bit, and port res_ready, input, 1 bit: result handshake.
REQ-016 SHALL have port busy, output, 1 bit: scan in progress.
REQ-017 SHALL have port scan_done, output, 1 bit: one-cycle pulse at single-shot completion.
REQ-018 SHALL have port overrun, output, 1 bit: sticky dropped-sample flag.

Function
REQ-019 States SHALL be IDLE, SETTLE and CAPTURE; busy SHALL be 1 in every state except IDLE.
REQ-020 In IDLE, start=1 with chan_mask!=0 SHALL latch chan_mask into an internal snapshot, set mux_sel to the lowest enabled channel, clear overrun, load the discard counter with DISCARD_SAMPLES and enter SETTLE on the next cycle.
REQ-021 In IDLE, start=1 with chan_mask==0 SHALL be ignored; start SHALL be ignored outside IDLE.
REQ-022 SETTLE: each adc_valid SHALL decrement the counter, dropping the sample; the pulse that brings the counter to 0 SHALL move the FSM to CAPTURE. DISCARD_SAMPLES=0 SHALL skip SETTLE.
REQ-023 CAPTURE: adc_valid while the result slot is free (res_valid=0, or res_ready=1 in the same cycle) SHALL load res_data/res_channel, assert res_valid on the next cycle, and advance the channel.
REQ-024 CAPTURE: adc_valid while the slot is occupied and res_ready=0 SHALL drop the sample, set overrun, and remain in CAPTURE.
REQ-025 Advance SHALL select the next higher enabled channel in the snapshot and enter SETTLE. Past the highest enabled channel: continuous=1 wraps to the lowest enabled channel; continuous=0 enters IDLE and pulses scan_done for one cycle.
REQ-026 If the advanced channel equals the current mux_sel (single-channel continuous scan), the FSM SHALL stay in CAPTURE with no discard.
REQ-027 res_valid SHALL stay high, with res_data and res_channel stable, until a cycle with res_ready=1; it SHALL clear on the next cycle unless a new capture occurs in that same cycle.
REQ-028 stop=1 SHALL force IDLE on the next cycle from any state, without altering a pending result; if start and stop are both high, stop SHALL win.
REQ-029 mux_sel SHALL change only on a start or an advance, and SHALL hold its value in IDLE.
REQ-030 Changes to chan_mask during a scan SHALL have no effect until the next start.

Reset
REQ-031 When rst=0, the block SHALL go immediately to IDLE with mux_sel=0, res_data=0, res_channel=0, res_valid=0, busy=0, scan_done=0, overrun=0, and discard counter=0.
REQ-032 Reset mid-handshake SHALL discard the pending result.

Structure
REQ-033 The state enum and a CHAN_W=$clog2(NUM_CHANNELS) helper SHALL reside in shared package sigma_delta_pkg.
REQ-034 The next-enabled-channel search (with wrap indication) SHALL be the combinational sub-module sigma_delta_chan_picker.

Verification
Parameters for all scenarios: NUM_CHANNELS=4, DISCARD_SAMPLES=2.
REQ-035 Single-shot: mask=4'b1011, res_ready=1 -> results for channels 0, 1, 3, each on the 3rd adc_valid after its mux change; scan_done pulses once; busy drops.
REQ-036 Backpressure: res_ready=0 after the first result -> the next capture sets overrun and the FSM holds CAPTURE; raising res_ready -> the following sample is captured.
REQ-037 Continuous: mask=4'b0100 -> mux_sel=2 constant; after 2 discards, every adc_valid yields a result.
REQ-038 start with mask=0 -> busy stays 0 and no res_valid.
REQ-039 stop mid-SETTLE -> IDLE next cycle with no result; start and stop together in IDLE -> stays IDLE.
REQ-040 rst asserted while res_valid=1 and res_ready=0 -> res_valid=0 immediately and all outputs at their reset values.

Source files
------------

// File: rtl/sigma_delta_pkg.sv
// Shared types and helpers for the sigma-delta ADC channel sequencer.
// Imported by the sequencer top and its channel picker.
package sigma_delta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } seq_state_e;

    // Channel index width; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CHAN_W = chan_w(4);

endpackage

// File: rtl/sigma_delta_chan_picker.sv
// Finds the lowest enabled channel and the next enabled channel above cur_i.
// wrap_o is set when nothing above cur_i is enabled; next_o then wraps to first_o.
module sigma_delta_chan_picker
    import sigma_delta_pkg::*;
#(
    parameter int N = 4,
    parameter int W = chan_w(N)
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] cur_i,
    output logic [W-1:0] first_o,
    output logic [W-1:0] next_o,
    output logic         wrap_o
);

    always_comb begin
        first_o = '0;
        next_o  = '0;
        wrap_o  = 1'b1;
        // Descending scans leave the lowest qualifying index behind.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                first_o = W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'(cur_i))) begin
                next_o = W'(i);
                wrap_o = 1'b0;
            end
        end
        if (wrap_o) begin
            next_o = first_o;
        end
    end

endmodule

// File: rtl/sigma_delta_adc_sequencer.sv
// Scans enabled analog-mux channels through one sigma-delta ADC, dropping
// CIC settling samples after each mux change and handing out one result at a time.
module sigma_delta_adc_sequencer
    import sigma_delta_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int ADC_BITLEN      = 16,
    parameter int DISCARD_SAMPLES = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                stop,
    input  logic                                continuous,
    input  logic [NUM_CHANNELS-1:0]             chan_mask,
    input  logic signed [ADC_BITLEN-1:0]        adc_s_sample,
    input  logic                                adc_valid,
    output logic [chan_w(NUM_CHANNELS)-1:0]     mux_sel,
    output logic [ADC_BITLEN-1:0]               res_data,
    output logic [chan_w(NUM_CHANNELS)-1:0]     res_channel,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic                                busy,
    output logic                                scan_done,
    output logic                                overrun
);

    localparam int CW    = chan_w(NUM_CHANNELS);
    localparam int CNT_W = (DISCARD_SAMPLES > 0) ? $clog2(DISCARD_SAMPLES + 1) : 1;
    localparam logic [CNT_W-1:0] DISC = CNT_W'(DISCARD_SAMPLES);

    seq_state_e              state_q, state_d;
    logic [NUM_CHANNELS-1:0] snap_q, snap_d;
    logic [CW-1:0]           mux_q, mux_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADC_BITLEN-1:0]   data_q, data_d;
    logic [CW-1:0]           chan_q, chan_d;
    logic                    rvalid_q, rvalid_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;

    logic [NUM_CHANNELS-1:0] pick_mask;
    logic [CW-1:0]           pick_first;
    logic [CW-1:0]           pick_next;
    logic                    pick_wrap;

    // In IDLE the live mask picks the first channel; afterwards only the snapshot counts.
    assign pick_mask = (state_q == ST_IDLE) ? chan_mask : snap_q;

    sigma_delta_chan_picker #(
        .N (NUM_CHANNELS),
        .W (CW)
    ) u_picker (
        .mask_i  (pick_mask),
        .cur_i   (mux_q),
        .first_o (pick_first),
        .next_o  (pick_next),
        .wrap_o  (pick_wrap)
    );

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        mux_d    = mux_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        chan_d   = chan_q;
        rvalid_d = rvalid_q & ~res_ready;
        done_d   = 1'b0;
        ovr_d    = ovr_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && (chan_mask != '0)) begin
                        snap_d  = chan_mask;
                        mux_d   = pick_first;
                        ovr_d   = 1'b0;
                        cnt_d   = DISC;
                        state_d = (DISCARD_SAMPLES == 0) ? ST_CAPTURE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (adc_valid) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (adc_valid && (!rvalid_q || res_ready)) begin
                        data_d   = adc_s_sample;
                        chan_d   = mux_q;
                        rvalid_d = 1'b1;
                        if (pick_wrap && !continuous) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (pick_next != mux_q) begin
                            mux_d   = pick_next;
                            cnt_d   = DISC;
                            state_d = (DISCARD_SAMPLES == 0) ? ST_CAPTURE : ST_SETTLE;
                        end
                    end else if (adc_valid) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            snap_q   <= '0;
            mux_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            chan_q   <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            mux_q    <= mux_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign mux_sel     = mux_q;
    assign res_data    = data_q;
    assign res_channel = chan_q;
    assign res_valid   = rvalid_q;
    assign busy        = (state_q != ST_IDLE);
    assign scan_done   = done_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_sigma_delta_adc_sequencer.sv
// Bench for the sigma-delta ADC sequencer: list-based scan model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_sigma_delta_adc_sequencer;

    localparam int NC   = 4;
    localparam int BL   = 16;
    localparam int DISC = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              continuous;
    logic [NC-1:0]     chan_mask;
    logic signed [BL-1:0] adc_s_sample;
    logic              adc_valid;
    logic [1:0]        mux_sel;
    logic [BL-1:0]     res_data;
    logic [1:0]        res_channel;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic              scan_done;
    logic              overrun;

    int checks = 0;
    int errors = 0;

    sigma_delta_adc_sequencer #(
        .NUM_CHANNELS    (NC),
        .ADC_BITLEN      (BL),
        .DISCARD_SAMPLES (DISC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .chan_mask    (chan_mask),
        .adc_s_sample (adc_s_sample),
        .adc_valid    (adc_valid),
        .mux_sel      (mux_sel),
        .res_data     (res_data),
        .res_channel  (res_channel),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .scan_done    (scan_done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Scan model: ordered list of enabled channels, a position in it, and
    // the number of samples still to drop before the next capture.
    int          m_list[$];
    int          m_pos  = 0;
    int          m_left = 0;
    int          m_mux  = 0;
    bit          m_busy = 0;
    bit          m_rv   = 0;
    logic [15:0] m_rd   = '0;
    int          m_rc   = 0;
    bit          m_done = 0;
    bit          m_ovr  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_list.delete();
            m_pos = 0; m_left = 0; m_mux = 0; m_busy = 0;
            m_rv = 0; m_rd = '0; m_rc = 0; m_done = 0; m_ovr = 0;
        end else begin
            bit nrv;
            bit ndone;
            int prev;
            nrv   = m_rv && !res_ready;
            ndone = 0;
            if (stop) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (start && chan_mask != 0) begin
                    m_list.delete();
                    for (int i = 0; i < NC; i++) if (chan_mask[i]) m_list.push_back(i);
                    m_pos = 0; m_mux = m_list[0]; m_ovr = 0;
                    m_left = DISC; m_busy = 1;
                end
            end else if (adc_valid) begin
                if (m_left > 0) begin
                    m_left--;
                end else if (m_rv && !res_ready) begin
                    m_ovr = 1;
                end else begin
                    nrv = 1; m_rd = adc_s_sample; m_rc = m_mux;
                    m_pos++;
                    if (m_pos == m_list.size()) begin
                        if (continuous) m_pos = 0;
                        else begin m_busy = 0; ndone = 1; end
                    end
                    if (m_busy) begin
                        prev   = m_mux;
                        m_mux  = m_list[m_pos];
                        m_left = (m_mux == prev) ? 0 : DISC;
                    end
                end
            end
            m_rv   = nrv;
            m_done = ndone;
        end
    end

    int got_ch[$];
    int got_dat[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("mux_sel", 32'(mux_sel), 32'(m_mux));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("res_data", 32'(res_data), 32'(m_rd));
        chk("res_channel", 32'(res_channel), 32'(m_rc));
        chk("scan_done", 32'(scan_done), 32'(m_done));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (rst && res_valid === 1'b1 && res_ready === 1'b1) begin
            got_ch.push_back(int'(res_channel));
            got_dat.push_back(int'(res_data));
        end
        if (scan_done === 1'b1) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] s, input int gap);
        adc_s_sample = s;
        adc_valid    = 1'b1;
        cyc();
        adc_valid    = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic clear_log();
        got_ch.delete();
        got_dat.delete();
        done_cnt = 0;
    endtask

    function automatic int gch(input int i);
        return (i < got_ch.size()) ? got_ch[i] : -1;
    endfunction

    function automatic int gdat(input int i);
        return (i < got_dat.size()) ? got_dat[i] : -1;
    endfunction

    initial begin
        rst = 1'b1; start = 0; stop = 0; continuous = 0; chan_mask = '0;
        adc_s_sample = '0; adc_valid = 0; res_ready = 0;
        #3 rst = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mux", 32'(mux_sel), 0);
        chk("rst_rv", 32'(res_valid), 0);
        rst = 1'b1;
        cyc();

        // Single shot 1011; mask changed after start must not matter.
        clear_log();
        res_ready = 1; continuous = 0; chan_mask = 4'b1011;
        do_start();
        chan_mask = 4'b0000;
        for (int k = 1; k <= 9; k++) pulse(16'hF000 + 16'(k), 1);
        repeat (3) cyc();
        chk("ss_n", 32'(got_ch.size()), 3);
        chk("ss_ch0", 32'(gch(0)), 0);
        chk("ss_d0", 32'(gdat(0)), 32'hF003);
        chk("ss_ch1", 32'(gch(1)), 1);
        chk("ss_d1", 32'(gdat(1)), 32'hF006);
        chk("ss_ch2", 32'(gch(2)), 3);
        chk("ss_d2", 32'(gdat(2)), 32'hF009);
        chk("ss_done", 32'(done_cnt), 1);
        chk("ss_busy", 32'(busy), 0);

        // Backpressure: slot held, next capture overruns, then recovers.
        clear_log();
        res_ready = 0; chan_mask = 4'b0011;
        do_start();
        for (int k = 1; k <= 6; k++) pulse(16'h0200 + 16'(k), 1);
        chk("bp_ovr", 32'(overrun), 1);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_ch", 32'(res_channel), 0);
        chk("bp_dat", 32'(res_data), 32'h0203);
        res_ready = 1;
        cyc();
        pulse(16'h0207, 2);
        chk("bp_n", 32'(got_ch.size()), 2);
        chk("bp_ch1", 32'(gch(1)), 1);
        chk("bp_d1", 32'(gdat(1)), 32'h0207);
        chk("bp_ovr_sticky", 32'(overrun), 1);

        // Continuous single channel, back-to-back samples.
        clear_log();
        continuous = 1; chan_mask = 4'b0100;
        do_start();
        for (int k = 1; k <= 8; k++) pulse(16'h0300 + 16'(k), 0);
        cyc();
        chk("ct_mux", 32'(mux_sel), 2);
        chk("ct_n", 32'(got_ch.size()), 6);
        chk("ct_d5", 32'(gdat(5)), 32'h0308);
        chk("ct_ovr", 32'(overrun), 0);
        stop = 1; cyc(); stop = 0;
        chk("ct_stop", 32'(busy), 0);

        // Continuous two channels with wrap.
        clear_log();
        chan_mask = 4'b1001;
        do_start();
        for (int k = 1; k <= 8; k++) pulse(16'h0400 + 16'(k), 1);
        chk("wr_n", 32'(got_ch.size()), 2);
        chk("wr_ch1", 32'(gch(1)), 3);
        chk("wr_mux", 32'(mux_sel), 0);
        stop = 1; cyc(); stop = 0;
        continuous = 0;

        // Empty mask start is ignored.
        clear_log();
        chan_mask = 4'b0000;
        do_start();
        for (int k = 1; k <= 4; k++) pulse(16'h0500 + 16'(k), 1);
        chk("zm_busy", 32'(busy), 0);
        chk("zm_n", 32'(got_ch.size()), 0);

        // Stop during settling, then start+stop together.
        clear_log();
        chan_mask = 4'b0001;
        do_start();
        pulse(16'h0601, 1);
        stop = 1; cyc(); stop = 0;
        chk("sp_busy", 32'(busy), 0);
        for (int k = 2; k <= 4; k++) pulse(16'h0600 + 16'(k), 1);
        chk("sp_n", 32'(got_ch.size()), 0);
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        chk("ss_both", 32'(busy), 0);
        cyc();
        chk("ss_both2", 32'(busy), 0);

        // Reset with a result pending.
        res_ready = 0; chan_mask = 4'b0011;
        do_start();
        for (int k = 1; k <= 3; k++) pulse(16'h0700 + 16'(k), 1);
        chk("rs_rv_pre", 32'(res_valid), 1);
        chk("rs_busy_pre", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("rs_rv", 32'(res_valid), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_mux", 32'(mux_sel), 0);
        chk("rs_dat", 32'(res_data), 0);
        chk("rs_ch", 32'(res_channel), 0);
        chk("rs_ovr", 32'(overrun), 0);
        chk("rs_done", 32'(scan_done), 0);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
